// File: rtl/spi_trace_pkg.sv
// Shared types and ASCII constants for the SPI trace transmit scheduler.
// Holds the character FSM enum, the per-character sub-phase enum and constants.
package spi_trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        HI,
        LO,
        SEP,
        CR,
        LF
    } state_t;

    typedef enum logic [1:0] {
        PULSE,
        ACK,
        DRAIN
    } phase_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_GT      = 8'h3E;
    localparam logic [7:0] ASCII_LT      = 8'h3C;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_HEX_OFS = 8'h37;

endpackage

// File: rtl/spi_trace_tx_sched_if.sv
// Bundle of the two source byte handshakes and the UART transmitter link.
// master: scheduler side (drives readies, tx_start/tx_data, idle, last_src).
interface spi_trace_tx_sched_if;

    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       idle;
    logic       last_src;

    modport master (
        input  a_valid, a_data, b_valid, b_data, tx_busy,
        output a_ready, b_ready, tx_start, tx_data, idle, last_src
    );

    modport slave (
        output a_valid, a_data, b_valid, b_data, tx_busy,
        input  a_ready, b_ready, tx_start, tx_data, idle, last_src
    );

endinterface

// File: rtl/spi_trace_tx_sched_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
// Ports: nib (4-bit value in), chr (ASCII character out).
module hex_ascii
    import spi_trace_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] chr
);

    assign chr = (nib < 4'd10) ? (ASCII_ZERO + {4'd0, nib})
                               : (ASCII_HEX_OFS + {4'd0, nib});

endmodule

// File: rtl/spi_trace_tx_sched.sv
// Round-robin scheduler turning MOSI/MISO trace bytes into ASCII hex for a UART.
// Ports: clk, nrst (async active-low), bus (spi_trace_tx_sched_if.master).
// Define SPI_TRACE_TAG_EN to prefix each byte with '>' (A) or '<' (B).
module spi_trace_tx_sched
    import spi_trace_pkg::*;
#(
    parameter logic [7:0]  SEP_CHAR   = 8'h20,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    spi_trace_tx_sched_if.master        bus
);

`ifdef SPI_TRACE_TAG_EN
    localparam state_t FIRST_STATE = TAG;
`else
    localparam state_t FIRST_STATE = HI;
`endif

    localparam logic [8:0] LB9 = 9'(LINE_BYTES);

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic       in_idle;
    logic       grant_a, grant_b;
    logic       a_rdy, b_rdy;
    logic       start;
    logic       char_done;
    logic       line_end;
    logic [8:0] cnt_inc;
    logic [7:0] hi_chr, lo_chr;
    logic [7:0] ch;

    hex_ascii u_hi (.nib(data_q[7:4]), .chr(hi_chr));
    hex_ascii u_lo (.nib(data_q[3:0]), .chr(lo_chr));

    assign in_idle = (state_q == IDLE);

    // Contention goes to the source that did not win last time.
    assign grant_a = bus.a_valid && (!bus.b_valid || last_q);
    assign grant_b = bus.b_valid && (!bus.a_valid || !last_q);

    // nrst gates the readies so nothing looks acceptable while held in reset.
    assign a_rdy = nrst && in_idle && grant_a;
    assign b_rdy = nrst && in_idle && grant_b;

    assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
    assign line_end = (LB9 != 9'd0) && (cnt_inc == LB9);

    always_comb begin
        ch = 8'h00;
        unique case (state_q)
            IDLE: ch = 8'h00;
`ifdef SPI_TRACE_TAG_EN
            TAG:  ch = last_q ? ASCII_LT : ASCII_GT;
`else
            TAG:  ch = 8'h00;
`endif
            HI:   ch = hi_chr;
            LO:   ch = lo_chr;
            SEP:  ch = SEP_CHAR;
            CR:   ch = ASCII_CR;
            LF:   ch = ASCII_LF;
            default: ch = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        char_done = 1'b0;

        if (in_idle) begin
            if (a_rdy || b_rdy) begin
                data_d  = a_rdy ? bus.a_data : bus.b_data;
                last_d  = b_rdy;
                state_d = FIRST_STATE;
                phase_d = PULSE;
            end
        end else begin
            unique case (phase_q)
                PULSE: begin
                    if (!bus.tx_busy) begin
                        start   = 1'b1;
                        phase_d = ACK;
                    end
                end
                ACK: begin
                    if (bus.tx_busy) begin
                        phase_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.tx_busy) begin
                        char_done = 1'b1;
                        phase_d   = PULSE;
                    end
                end
                default: phase_d = PULSE;
            endcase
        end

        if (char_done) begin
            unique case (state_q)
                TAG: state_d = HI;
                HI:  state_d = LO;
                LO:  state_d = line_end ? CR : SEP;
                SEP: begin
                    state_d = IDLE;
                    // Saturate so a disabled line length cannot wrap.
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
                end
                CR:  state_d = LF;
                LF: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            phase_q <= PULSE;
            data_q  <= 8'h00;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.a_ready  = a_rdy;
    assign bus.b_ready  = b_rdy;
    assign bus.tx_start = start;
    assign bus.tx_data  = ch;
    assign bus.idle     = in_idle;
    assign bus.last_src = last_q;

endmodule

// File: tb/tb_spi_trace_tx_sched.sv
// Self-checking bench for spi_trace_tx_sched with a queue-based character model.
// Drives directed byte scenarios through a UART busy responder.
module tb_spi_trace_tx_sched;

    localparam int LB = 2;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    spi_trace_tx_sched_if bus();

    spi_trace_tx_sched #(
        .SEP_CHAR   (8'h20),
        .LINE_BYTES (LB)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    logic busy_m = 1'b0;
    logic busy_force = 1'b0;
    assign bus.tx_busy = busy_m | busy_force;

    int total = 0;
    int bad = 0;
    byte unsigned exp_q[$];
    byte unsigned log_q[$];
    bit mlast = 1'b1;
    int mcnt = 0;
    int busy_len = 3;
    int start_cnt = 0;
    bit prev_start = 1'b0;
    bit cap_valid = 1'b0;
    logic [7:0] cap = 8'h00;
    string hexs = "0123456789ABCDEF";
`ifdef SPI_TRACE_TAG_EN
    string tag_a = ">";
    string tag_b = "<";
`else
    string tag_a = "";
    string tag_b = "";
`endif

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s got=timeout want=progress", name);
    endtask

    function automatic string hexdump(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
        return r;
    endfunction

    task automatic check_log(input string name, input string want);
        string g = "";
        foreach (log_q[i]) g = {g, $sformatf("%c", log_q[i])};
        total++;
        if (g != want) begin
            bad++;
            $display("FAIL %s got=[%s] want=[%s]", name, hexdump(g), hexdump(want));
        end
        log_q.delete();
    endtask

    // Model: a byte becomes [tag] hi lo and a separator or CR LF at line end.
    task automatic model_accept(input bit src, input logic [7:0] d);
        int n;
`ifdef SPI_TRACE_TAG_EN
        exp_q.push_back(src ? 8'h3C : 8'h3E);
`endif
        exp_q.push_back(hexs[d[7:4]]);
        exp_q.push_back(hexs[d[3:0]]);
        n = mcnt + 1;
        if (LB != 0 && n == LB) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            mcnt = 0;
        end else begin
            exp_q.push_back(8'h20);
            mcnt = n;
        end
        mlast = src;
    endtask

    task automatic monitor();
        logic ea, eb;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                exp_q.delete();
                mlast = 1'b1;
                mcnt = 0;
                cap_valid = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (bus.tx_start) begin
                    check("start_width", prev_start, 0);
                    check("start_while_busy", bus.tx_busy, 0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_char got=%02h want=none", bus.tx_data);
                    end else begin
                        check("char", bus.tx_data, exp_q.pop_front());
                    end
                    log_q.push_back(bus.tx_data);
                    cap = bus.tx_data;
                    cap_valid = 1'b1;
                    start_cnt++;
                end else if (bus.tx_busy && cap_valid) begin
                    check("data_hold", bus.tx_data, cap);
                end
                prev_start = bus.tx_start;
                check("last_src", bus.last_src, mlast);
                if (bus.a_ready || bus.b_ready) begin
                    ea = bus.a_valid && (!bus.b_valid || mlast);
                    eb = bus.b_valid && (!bus.a_valid || !mlast);
                    check("ready_pair", {bus.a_ready, bus.b_ready}, {ea, eb});
                end
                if (bus.a_valid && bus.a_ready) model_accept(1'b0, bus.a_data);
                else if (bus.b_valid && bus.b_ready) model_accept(1'b1, bus.b_data);
            end
        end
    endtask

    // UART stand-in: busy for busy_len cycles starting after each start pulse.
    task automatic responder();
        int seen = 0;
        int bc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (start_cnt != seen) begin
                seen = start_cnt;
                busy_m = 1'b1;
                bc = busy_len;
            end else if (busy_m) begin
                if (bc <= 1) busy_m = 1'b0;
                else bc--;
            end
        end
    endtask

    task automatic do_reset(input bit checks);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        if (checks) begin
            check("rst_tx_start", bus.tx_start, 0);
            check("rst_tx_data", bus.tx_data, 0);
            check("rst_a_ready", bus.a_ready, 0);
            check("rst_b_ready", bus.b_ready, 0);
            check("rst_idle", bus.idle, 1);
            check("rst_last_src", bus.last_src, 1);
        end
        @(negedge clk);
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        log_q.delete();
    endtask

    task automatic send(input bit src, input logic [7:0] d);
        int i;
        @(posedge clk);
        #1;
        if (src) begin
            bus.b_valid = 1'b1;
            bus.b_data = d;
        end else begin
            bus.a_valid = 1'b1;
            bus.a_data = d;
        end
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (src ? bus.b_ready : bus.a_ready) break;
        end
        if (i == 4000) fail_now("send_accept");
        @(posedge clk);
        #1;
        if (src) bus.b_valid = 1'b0;
        else bus.a_valid = 1'b0;
    endtask

    task automatic send_both(input logic [7:0] da, input logic [7:0] db);
        int i;
        bit ga = 1'b0;
        bit gb = 1'b0;
        bit ra, rb;
        @(posedge clk);
        #1;
        bus.a_valid = 1'b1;
        bus.a_data = da;
        bus.b_valid = 1'b1;
        bus.b_data = db;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            ra = bus.a_ready;
            rb = bus.b_ready;
            if (ra || rb) begin
                @(posedge clk);
                #1;
                if (ra) begin
                    bus.a_valid = 1'b0;
                    ga = 1'b1;
                end
                if (rb) begin
                    bus.b_valid = 1'b0;
                    gb = 1'b1;
                end
                if (ga && gb) break;
            end
        end
        if (i == 4000) fail_now("send_both_accept");
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.idle && !bus.tx_busy) break;
        end
        if (i == 4000) fail_now(name);
    endtask

    initial begin
        int hits;
        int k;
        bus.a_valid = 1'b0;
        bus.a_data = 8'h00;
        bus.b_valid = 1'b0;
        bus.b_data = 8'h00;
        fork
            monitor();
            responder();
        join_none

        // Reset values, with both sources requesting during reset.
        do_reset(1'b1);

        // Single byte from A, 10-cycle transmitter.
        busy_len = 10;
        send(1'b0, 8'hBC);
        wait_done("bc_done");
        check_log("seq_bc", {tag_a, "BC "});
        check("idle_after_bc", bus.idle, 1);
        busy_len = 3;

        // Contention straight from reset: A first, then B; second byte ends the line.
        do_reset(1'b0);
        send_both(8'h25, 8'h0E);
        wait_done("rr_done");
        check_log("seq_rr", {tag_a, "25 ", tag_b, "0E\015\012"});

        // Line break after two bytes, counter cleared afterwards.
        do_reset(1'b0);
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        wait_done("line_done");
        check_log("seq_line", {tag_a, "01 ", tag_a, "02\015\012", tag_a, "03 "});

        // Transmitter busy for 50 cycles at acceptance.
        do_reset(1'b0);
        busy_force = 1'b1;
        send(1'b0, 8'h5A);
        hits = 0;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (bus.tx_start) hits++;
        end
        check("no_start_while_busy", hits, 0);
        @(posedge clk);
        #1;
        busy_force = 1'b0;
        @(negedge clk);
        check("start_after_busy", bus.tx_start, 1);
        wait_done("busy_done");
        check_log("seq_busy", {tag_a, "5A "});

        // Reset while the low nibble is on the wire.
        do_reset(1'b0);
        busy_len = 10;
        send(1'b0, 8'h3C);
        k = (tag_a.len() == 0) ? 2 : 3;
        hits = 0;
        while (log_q.size() < k && hits < 4000) begin
            @(negedge clk);
            hits++;
        end
        if (hits == 4000) fail_now("reach_lo");
        do_reset(1'b1);
        send(1'b0, 8'h7F);
        wait_done("restart_done");
        check_log("seq_restart", {tag_a, "7F "});
        busy_len = 3;

        // Single byte from B.
        do_reset(1'b0);
        send(1'b1, 8'hA5);
        wait_done("b_done");
        check_log("seq_b", {tag_b, "A5 "});
        check("last_src_b", bus.last_src, 1);

        // Mixed sources: B alone, then contention after B goes to A.
        do_reset(1'b0);
        send(1'b1, 8'h9F);
        send_both(8'hC3, 8'h48);
        send(1'b0, 8'hFF);
        send(1'b1, 8'h00);
        wait_done("mix_done");
        check_log("seq_mix", {tag_b, "9F ", tag_a, "C3\015\012", tag_b, "48 ",
                              tag_a, "FF\015\012", tag_b, "00 "});
        check("idle_end", bus.idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
